// File: rtl/sd_pkg.sv
// sd_pkg: shared types and protocol constants for the SPI-mode SD block writer.
//   sd_wr_state_t : writer FSM states
//   sd_err_t      : error codes reported on error_code
//   constants     : CMD24 opcode, data start token, data-response codes, idle fill byte
package sd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_R1,
        S_GAP,
        S_TOKEN,
        S_DATA,
        S_CRC,
        S_DRESP,
        S_BUSY,
        S_DONE,
        S_ERR
    } sd_wr_state_t;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_R1_TIMEOUT    = 3'd1,
        ERR_R1_NONZERO    = 3'd2,
        ERR_CRC           = 3'd3,
        ERR_WRITE         = 3'd4,
        ERR_DRESP_TIMEOUT = 3'd5,
        ERR_BUSY_TIMEOUT  = 3'd6,
        ERR_BAD_TOKEN     = 3'd7
    } sd_err_t;

    localparam logic [7:0] CMD24       = 8'h58;
    localparam logic [7:0] START_TOKEN = 8'hFE;
    localparam logic [7:0] DRESP_OK    = 8'h05;
    localparam logic [7:0] DRESP_CRC   = 8'h0B;
    localparam logic [7:0] DRESP_WR    = 8'h0D;
    localparam logic [7:0] IDLE_BYTE   = 8'hFF;

endpackage

// File: rtl/sd_block_writer.sv
// sd_block_writer: writes one 512-byte sector to an SPI-mode SD card with CMD24.
//   clk, rst_n            : clock, asynchronous active-low reset
//   addr_in, write_en     : sector address and start pulse (accepted only when idle)
//   busy, done, error     : transaction status; done/error are one-cycle pulses
//   error_code            : failure cause, held until the next accepted start
//   spi_tx_byte, spi_trigger, spi_rx_byte, spi_done : byte-engine handshake
//   cs_hold               : keeps the card selected for the whole transaction
//   ram_addr, ram_en, ram_dout : sector buffer read port (RAM_LATENCY cycles)
module sd_block_writer
    import sd_pkg::*;
#(
    parameter int RAM_DEPTH   = 512,
    parameter int RAM_LATENCY = 2,
    parameter int NCR_MAX     = 8,
    parameter int BUSY_MAX    = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  addr_in,
    input  logic                         write_en,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [2:0]                   error_code,
    output logic [7:0]                   spi_tx_byte,
    output logic                         spi_trigger,
    input  logic [7:0]                   spi_rx_byte,
    input  logic                         spi_done,
    output logic                         cs_hold,
    output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
    output logic                         ram_en,
    input  logic [7:0]                   ram_dout
);

    localparam int AW   = $clog2(RAM_DEPTH);
    localparam int PMAX = NCR_MAX > BUSY_MAX ? NCR_MAX : BUSY_MAX;
    localparam int PW   = $clog2(PMAX + 1);

    sd_wr_state_t         state, state_n;
    sd_err_t              code, code_n;
    logic [31:0]          addr_q;
    logic [9:0]           idx, idx_n;
    logic [PW-1:0]        poll, poll_n;
    logic                 pend, adv, launch, fetch;
    logic [7:0]           tx_n, cmd_byte, resp, pref;
    logic [RAM_LATENCY-1:0] vld;

    assign resp = spi_rx_byte & 8'h1F;

    always_comb begin
        state_n = state;
        code_n  = code;
        idx_n   = idx;
        poll_n  = poll;
        // Only a spi_done that answers our own outstanding byte moves the FSM.
        adv     = pend && spi_done;
        case (state)
            S_IDLE: if (write_en) begin
                state_n = S_CMD;
                code_n  = ERR_NONE;
            end
            S_CMD: if (adv) begin
                if (idx == 10'd5) state_n = S_R1;
                else idx_n = idx + 10'd1;
            end
            S_R1: if (adv) begin
                if (spi_rx_byte != IDLE_BYTE) begin
                    state_n = spi_rx_byte == 8'h00 ? S_GAP : S_ERR;
                    code_n  = spi_rx_byte == 8'h00 ? code : ERR_R1_NONZERO;
                end else if (poll == PW'(NCR_MAX - 1)) begin
                    state_n = S_ERR;
                    code_n  = ERR_R1_TIMEOUT;
                end else poll_n = poll + 1'b1;
            end
            S_GAP:   if (adv) state_n = S_TOKEN;
            S_TOKEN: if (adv) state_n = S_DATA;
            S_DATA: if (adv) begin
                if (idx == 10'd511) state_n = S_CRC;
                else idx_n = idx + 10'd1;
            end
            S_CRC: if (adv) begin
                if (idx == 10'd1) state_n = S_DRESP;
                else idx_n = idx + 10'd1;
            end
            S_DRESP: if (adv) begin
                if (spi_rx_byte != IDLE_BYTE) begin
                    state_n = resp == DRESP_OK ? S_BUSY : S_ERR;
                    code_n  = resp == DRESP_OK  ? code :
                              resp == DRESP_CRC ? ERR_CRC :
                              resp == DRESP_WR  ? ERR_WRITE : ERR_BAD_TOKEN;
                end else if (poll == PW'(NCR_MAX - 1)) begin
                    state_n = S_ERR;
                    code_n  = ERR_DRESP_TIMEOUT;
                end else poll_n = poll + 1'b1;
            end
            S_BUSY: if (adv) begin
                if (spi_rx_byte == IDLE_BYTE) state_n = S_DONE;
                else if (poll == PW'(BUSY_MAX - 1)) begin
                    state_n = S_ERR;
                    code_n  = ERR_BUSY_TIMEOUT;
                end else poll_n = poll + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        // Every state entry restarts both the byte index and the poll count.
        if (state_n != state) begin
            idx_n  = '0;
            poll_n = '0;
        end
        cmd_byte = idx_n == 10'd0 ? CMD24 :
                   idx_n == 10'd1 ? addr_q[31:24] :
                   idx_n == 10'd2 ? addr_q[23:16] :
                   idx_n == 10'd3 ? addr_q[15:8] :
                   idx_n == 10'd4 ? addr_q[7:0] : IDLE_BYTE;
        tx_n     = state_n == S_CMD   ? cmd_byte :
                   state_n == S_TOKEN ? START_TOKEN :
                   state_n == S_DATA  ? pref : IDLE_BYTE;
        // A byte is launched on accept, and right after each completed byte
        // whenever the next state still has something to shift.
        launch   = !(state_n inside {S_IDLE, S_DONE, S_ERR}) && (state == S_IDLE || adv);
        // The token fetches byte 0; data byte n fetches byte n+1 while it shifts.
        fetch    = launch && (state_n == S_TOKEN || (state_n == S_DATA && idx_n != 10'd511));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            code        <= ERR_NONE;
            addr_q      <= '0;
            idx         <= '0;
            poll        <= '0;
            pend        <= 1'b0;
            spi_trigger <= 1'b0;
            spi_tx_byte <= IDLE_BYTE;
            ram_en      <= 1'b0;
            ram_addr    <= '0;
            vld         <= '0;
            pref        <= '0;
        end else begin
            state       <= state_n;
            code        <= code_n;
            idx         <= idx_n;
            poll        <= poll_n;
            if (state == S_IDLE && write_en) addr_q <= addr_in;
            pend        <= launch || (pend && !spi_done);
            spi_trigger <= launch;
            if (launch) spi_tx_byte <= tx_n;
            ram_en      <= fetch;
            if (fetch) ram_addr <= state_n == S_TOKEN ? '0 : AW'(idx_n + 10'd1);
            vld[0]      <= ram_en;
            for (int i = 1; i < RAM_LATENCY; i++) vld[i] <= vld[i-1];
            if (vld[RAM_LATENCY-1]) pref <= ram_dout;
        end
    end

    assign busy       = !(state inside {S_IDLE, S_DONE, S_ERR});
    assign cs_hold    = busy;
    assign done       = state == S_DONE;
    assign error      = state == S_ERR;
    assign error_code = code;

endmodule

// File: doc/sd_block_writer.md
Name: sd_block_writer

Overview:
- SPI-mode SD host block that writes one 512-byte sector to the card with CMD24 (WRITE_BLOCK).
- Source data comes from a byte-wide sector buffer RAM.
- Drives the shared 8-bit SPI byte engine (spi_con, DATA_WIDTH=8) through a trigger/done handshake, checks R1, the data-response token and card busy, and reports done or a coded error.
- Write-direction companion to the sector reader; sits beside it under the SD top-level arbiter.

Parameters:
- RAM_DEPTH, 512, sector buffer depth in bytes; must be >= 512. Only addresses 0..511 are used.
- RAM_LATENCY, 2, cycles from ram_en/ram_addr to valid ram_dout.
- NCR_MAX, 8, maximum 0xFF poll bytes allowed before R1 or the data response.
- BUSY_MAX, 65535, maximum poll bytes allowed while the card holds busy (MISO = 0x00).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr_in  in  32  sector (block) address, SDHC addressing
- write_en  in  1  start pulse; sampled only in IDLE
- busy  out  1  high from accept to done/error
- done  out  1  one-cycle pulse on successful write
- error  out  1  one-cycle pulse on failure
- error_code  out  3  failure cause; held until next accepted start
- spi_tx_byte  out  8  byte to shift out
- spi_trigger  out  1  one-cycle start pulse for the byte engine
- spi_rx_byte  in  8  byte shifted in; valid with spi_done
- spi_done  in  1  one-cycle byte-complete pulse
- cs_hold  out  1  high to keep SD chip select asserted across the transaction
- ram_addr  out  $clog2(RAM_DEPTH)  sector buffer read address
- ram_en  out  1  sector buffer read enable
- ram_dout  in  8  sector buffer read data

Behaviour:
- Reset (async, rst_n low): FSM goes to IDLE; busy, done, error, spi_trigger, cs_hold, ram_en = 0; error_code = 0; spi_tx_byte = 0xFF; ram_addr = 0.
- Byte handshake:
  - spi_trigger is pulsed one cycle with spi_tx_byte already stable.
  - spi_tx_byte is held until spi_done.
  - The next trigger is issued the cycle after spi_done. Exactly one byte is outstanding at a time.
- IDLE: on write_en, latch addr_in, clear error_code, set busy and cs_hold, go to CMD. write_en while busy is ignored.
- CMD: send 6 bytes: 0x58, addr[31:24], addr[23:16], addr[15:8], addr[7:0], 0xFF.
- R1: send 0xFF, count polls.
  - First rx != 0xFF: 0x00 goes to GAP; any other value gives error code 2.
  - NCR_MAX polls with all 0xFF gives code 1.
- GAP: send one 0xFF (Nwr), then go to TOKEN.
- TOKEN: send 0xFE.
  - During TOKEN, issue ram_en with ram_addr = 0.
  - ram_dout is captured RAM_LATENCY cycles later into a 1-byte prefetch register.
- DATA: send 512 bytes in address order 0..511, using a 10-bit byte counter.
  - While byte n is shifting, prefetch byte n+1.
  - The engine byte time must exceed RAM_LATENCY+1 cycles; this holds for any spi_con divider >= 1.
  - ram_en is asserted only on prefetch cycles.
- CRC: send 0xFF, 0xFF (CRC disabled in SPI mode).
- DRESP: send 0xFF until rx != 0xFF, max NCR_MAX polls, then check rx & 0x1F:
  - 0x05: go to BUSY.
  - 0x0B: code 3.
  - 0x0D: code 4.
  - other: code 7.
  - timeout: code 5.
- BUSY: send 0xFF until rx == 0xFF gives DONE. Reaching BUSY_MAX polls gives code 6.
- DONE: pulse done for one cycle; busy and cs_hold drop in the same cycle; go to IDLE.
- ERR: latch error_code, pulse error for one cycle, drop busy and cs_hold, go to IDLE.
- Error codes: 1 R1 timeout, 2 R1 nonzero, 3 CRC reject, 4 write reject, 5 data-response timeout, 6 busy timeout, 7 bad token.
- Boundaries:
  - Poll counters reset on each state entry.
  - Byte counter terminal value is 511, with no wrap.
  - spi_done outside an outstanding byte is ignored.
  - Reset mid-transaction aborts immediately and releases cs_hold; no recovery bytes are sent.

Decomposition:
- Package sd_pkg holds:
  - state enum sd_wr_state_t;
  - constants CMD24 = 0x58, START_TOKEN = 0xFE, DRESP_OK = 0x05, DRESP_CRC = 0x0B, DRESP_WR = 0x0D;
  - the error code enum.
- No sub-module; the 6-byte command serializer is a local mux on the byte index.

Test Plan:
- addr_in=0x0000_1234, card model returns R1=0x00 on poll 2, DRESP=0xE5, 3 busy bytes, RAM[i]=i[7:0] -> engine sees 58 00 00 12 34 FF, FF×2, FF, FE, 00..FF×2, FF FF; then done pulse, error_code=0.
- R1 never leaves 0xFF -> exactly 8 polls, error pulse, error_code=1, cs_hold low.
- R1=0x04 -> error_code=2, no 0xFE token sent.
- DRESP=0x0B and, separately, 0x0D -> error_code 3 and 4 respectively; no busy polling.
- Busy held 0x00 with BUSY_MAX=16 -> 16 polls, then error_code=6.
- Second write_en mid-DATA is ignored; rst_n low at byte 300 -> all outputs at reset values asynchronously, and the next write_en restarts from CMD.
